// File: rtl/wide_sum_collector.sv
// Collects WORDS 16-bit adder slices (LSB first) into one wide result, feeding carry back to the adder.
// Result valid 1 cycle after the final slice; in_ready low while a result waits for res_ready.
module wide_sum_collector #(
   parameter int WORDS = 4,
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [15:0]           in_sum,
   input  logic                  in_cout,
   output logic                  carry_fb,
   output logic [CW-1:0]         beat_cnt,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [16*WORDS-1:0]   res_data,
   output logic                  res_carry
);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t state, state_nxt;
   logic   accept;
   logic   last_beat;

   assign in_ready  = (state != HOLD);
   assign accept    = in_valid && in_ready;
   assign last_beat = (beat_cnt == CW'(WORDS - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = last_beat ? HOLD : COLLECT;
         COLLECT: if (accept && last_beat) state_nxt = HOLD;
         HOLD:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         carry_fb  <= 1'b0;
         res_valid <= 1'b0;
         res_carry <= 1'b0;
         res_data  <= '0;
      end else if (clear) begin
         // abort keeps res_data so a consumer never sees it glitch to zero
         state     <= IDLE;
         beat_cnt  <= '0;
         carry_fb  <= 1'b0;
         res_valid <= 1'b0;
         res_carry <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            res_data[beat_cnt*16 +: 16] <= in_sum;
            if (last_beat) begin
               // zero the feedback so the next operation starts with cin=0
               res_carry <= in_cout;
               carry_fb  <= 1'b0;
               beat_cnt  <= '0;
               res_valid <= 1'b1;
            end else begin
               carry_fb  <= in_cout;
               beat_cnt  <= beat_cnt + CW'(1);
            end
         end
         if (res_valid && res_ready) res_valid <= 1'b0;
      end
   end

endmodule
